// File: rtl/acia_pkg.sv
// acia_pkg: shared constants for the ACIA receive path.
//   - FSM state encodings (IDLE, START, DATA, STOP)
//   - oversample ratio and the three majority-vote sample points
//   - data bits per frame
//   - maj3(): 3-input majority vote
package acia_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int OSR        = 16;
  localparam int SAMP_A     = 7;
  localparam int SAMP_B     = 8;
  localparam int SAMP_C     = 9;
  localparam int FRAME_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/acia_sync_fifo.sv
// acia_sync_fifo: first-word-fall-through FIFO for received bytes.
//   clk, reset : clock, synchronous active-high reset
//   wr, wdata  : push strobe and data
//   rd         : pop strobe (ignored while empty)
//   rdata      : head entry, reads as zero while empty
//   empty/full : status
//   ovf        : one-cycle pulse, a push was dropped because the FIFO was full
module acia_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok, rd_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is
  // still accepted (it lands in the slot being vacated).
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd);
  assign ovf   = wr & full & ~rd;

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/acia_rx_fifo.sv
// acia_rx_fifo: 8N1 serial receiver with 16x oversampling, 3-sample majority
// vote and a small FWFT byte FIFO.
//   clk, reset : clock, synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   rd         : pop the head byte
//   clr_err    : clear frame_err and overrun
//   rdata      : FIFO head byte (zero when empty)
//   rx_valid   : FIFO not empty
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte dropped on a full FIFO
module acia_rx_fifo
  import acia_pkg::*;
#(
  parameter int OSR_DIV    = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);
  localparam int PW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  logic          sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0]    settle_q, settle_d;
  logic          arm_q, arm_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    os_cnt_q, os_cnt_d;
  logic          s_a_q, s_a_d, s_b_q, s_b_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;

  logic tick, decide, samp_bit, start_edge, push, ferr_set, ovf, fifo_empty, fifo_full;

  assign tick     = (presc_q == PW'(OSR_DIV - 1));
  assign decide   = tick && (os_cnt_q == 4'(SAMP_C));
  assign samp_bit = maj3(s_a_q, s_b_q, sync2_q);
  // arm_q blocks a start until the synchronized line has been seen high after
  // reset, so a line held low across reset release is not taken as a start.
  assign start_edge = arm_q & hist_q & ~sync2_q;

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    arm_d       = arm_q | ((settle_q == 2'd3) & sync2_q);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    os_cnt_d    = tick ? os_cnt_q + 4'd1 : os_cnt_q;
    s_a_d       = (tick && os_cnt_q == 4'(SAMP_A)) ? sync2_q : s_a_q;
    s_b_d       = (tick && os_cnt_q == 4'(SAMP_B)) ? sync2_q : s_b_q;
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    push        = 1'b0;
    ferr_set    = 1'b0;
    case (state_q)
      ST_IDLE: if (start_edge) begin
        presc_d  = '0;
        os_cnt_d = '0;
        state_d  = ST_START;
      end
      ST_START: if (decide) begin
        state_d   = samp_bit ? ST_IDLE : ST_DATA;
        bit_idx_d = '0;
      end
      ST_DATA: if (decide) begin
        sh_d      = {samp_bit, sh_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'(FRAME_BITS - 1)) state_d = ST_STOP;
      end
      default: if (decide) begin
        // Leave STOP mid-bit so a following start edge is not missed.
        state_d  = ST_IDLE;
        push     = samp_bit;
        ferr_set = ~samp_bit;
      end
    endcase
    frame_err_d = ferr_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overrun_d   = ovf      ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      settle_q    <= '0;
      arm_q       <= 1'b0;
      presc_q     <= '0;
      os_cnt_q    <= '0;
      s_a_q       <= 1'b1;
      s_b_q       <= 1'b1;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      settle_q    <= settle_d;
      arm_q       <= arm_d;
      presc_q     <= presc_d;
      os_cnt_q    <= os_cnt_d;
      s_a_q       <= s_a_d;
      s_b_q       <= s_b_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  acia_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (sh_q),
    .rd    (rd),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ovf   (ovf)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_acia_rx_fifo.sv
module tb_acia_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, rx, rd, clr_err;
  logic [7:0] rdata;
  logic       rx_valid, frame_err, overrun;

  always #5 clk = ~clk;

  acia_rx_fifo #(.OSR_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .rdata     (rdata),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_fe;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rise_cyc;
  logic saw_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one 8N1 frame, 64 clk per bit. Records the clock count (from the
  // start-bit drive) at which rx_valid first rises. With rd_at_push set, rd is
  // asserted in the cycle the receiver pushes the byte.
  task automatic send(input logic [7:0] d, input logic stop, input logic rd_at_push);
    logic [9:0] fr;
    logic       was;
    int         n;
    fr = {stop, d, 1'b0};
    was = rx_valid;
    rise_cyc = -1;
    saw_push = 1'b0;
    n = 0;
    for (int b = 0; b < 10; b++) begin
      rx = fr[b];
      for (int c = 0; c < 64; c++) begin
        if (rd_at_push && dut.push) begin rd = 1'b1; saw_push = 1'b1; end
        @(posedge clk); #1;
        rd = 1'b0;
        n++;
        if (rx_valid && !was && rise_cyc < 0) rise_cyc = n;
        was = rx_valid;
      end
    end
    rx = 1'b1;
  endtask

  task automatic pop();
    rd = 1'b1; clks(1); rd = 1'b0;
  endtask

  task automatic clear();
    clr_err = 1'b1; clks(1); clr_err = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[4] = '{8'h6E, 1'b1, 1'b1, 8'h6E, 1'b0};

    rx = 1'b1; rd = 1'b0; clr_err = 1'b0; reset = 1'b1;
    clks(5);
    chk("reset_valid", rx_valid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_fe", frame_err, 0);
    chk("reset_ov", overrun, 0);
    reset = 1'b0;
    clks(20);

    // 1: single byte, latency
    send(8'hA5, 1'b1, 1'b0);
    clks(2);
    chk("t1_latency_window", (rise_cyc >= 605 && rise_cyc <= 625), 1);
    chk("t1_valid", rx_valid, 1);
    chk("t1_rdata", rdata, 8'hA5);
    chk("t1_fe", frame_err, 0);
    chk("t1_ov", overrun, 0);
    pop();
    chk("t1_valid_after_rd", rx_valid, 0);
    chk("t1_rdata_empty", rdata, 0);

    // 2: glitch is a false start
    rx = 1'b0; clks(16); rx = 1'b1;
    clks(700);
    chk("t2_valid", rx_valid, 0);
    chk("t2_fe", frame_err, 0);
    chk("t2_ov", overrun, 0);

    // 3 + table: framing error and several data patterns
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].stop, 1'b0);
      clks(4);
      chk($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_fe", i), frame_err, vecs[i].exp_fe);
      chk($sformatf("vec%0d_ov", i), overrun, 0);
      clear();
      chk($sformatf("vec%0d_fe_clr", i), frame_err, 0);
      chk($sformatf("vec%0d_valid_kept", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) pop();
      chk($sformatf("vec%0d_empty", i), rx_valid, 0);
      clks(20);
    end

    // 4: overrun on 5 back-to-back bytes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    clks(4);
    chk("t4_ov", overrun, 1);
    chk("t4_fe", frame_err, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_valid%0d", i), rx_valid, 1);
      chk($sformatf("t4_rdata%0d", i), rdata, 8'(i));
      pop();
    end
    chk("t4_empty", rx_valid, 0);
    clear();
    chk("t4_ov_clr", overrun, 0);
    clks(20);

    // 5: push into full FIFO with a simultaneous read
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1, 1'b0);
    chk("t5_full_head", rdata, 8'h11);
    send(8'h15, 1'b1, 1'b1);
    clks(4);
    chk("t5_saw_push", saw_push, 1);
    chk("t5_ov", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_rdata%0d", i), rdata, 8'h12 + 8'(i));
      pop();
    end
    chk("t5_empty", rx_valid, 0);
    clks(20);

    // 6: reset mid-frame with the line held low
    send(8'h77, 1'b1, 1'b0);
    clks(4);
    chk("t6_pre_valid", rx_valid, 1);
    rx = 1'b0; clks(64);
    rx = 1'b1; clks(192);
    rx = 1'b0; clks(5);
    reset = 1'b1; clks(3);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_rdata", rdata, 0);
    chk("t6_rst_fe", frame_err, 0);
    chk("t6_rst_ov", overrun, 0);
    clks(20);
    reset = 1'b0;
    clks(800);
    chk("t6_lowhold_valid", rx_valid, 0);
    chk("t6_lowhold_fe", frame_err, 0);
    rx = 1'b1; clks(100);
    send(8'h5A, 1'b1, 1'b0);
    clks(4);
    chk("t6_valid", rx_valid, 1);
    chk("t6_rdata", rdata, 8'h5A);
    chk("t6_fe", frame_err, 0);
    chk("t6_ov", overrun, 0);
    pop();
    chk("t6_empty", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
